// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. Operands and carry-in are accepted over a
// valid/ready handshake, then one bit pair per cycle (LSB first) is pushed
// through the full-adder equations with the running carry held in a register.
// Sum bits are shifted into a result register. The WIDTH-bit sum and the
// carry-out are presented over a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_valid   operands on in_a/in_b/in_cin are valid
//   in_ready   block can accept operands (high only in IDLE)
//   in_a       operand A, WIDTH bits
//   in_b       operand B, WIDTH bits
//   in_cin     carry-in
//   out_valid  out_sum/out_cout hold a completed result
//   out_ready  consumer accepts the result
//   out_sum    (in_a + in_b + in_cin) mod 2^WIDTH
//   out_cout   bit WIDTH of in_a + in_b + in_cin
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;

    // Full-adder cell on the current LSB pair.
    logic             w_s;
    logic             w_co;
    logic [WIDTH:0]   w_s_cat;
    logic [WIDTH-1:0] w_s_next;

    assign w_s  = r_a[0] ^ r_b[0] ^ r_c;
    assign w_co = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_c);

    // New sum bit enters at the MSB; concatenating then dropping the LSB
    // keeps this expression legal for WIDTH=1 as well.
    assign w_s_cat  = {w_s, r_s};
    assign w_s_next = w_s_cat[WIDTH:1];

    // NOTE: every register below is assigned with <= so all of them update
    // together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are cleared too, so the visible
            // outputs and the carry start from known zeros after reset.
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= 1'b0;
            r_s         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_c        <= in_cin;
                        r_s        <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_s   <= w_s_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_co;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // The output registers only change here, so the last
                        // result stays visible through the next IDLE and RUN.
                        r_out_sum   <= w_s_next;
                        r_out_cout  <= w_co;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Three serial_adder instances (WIDTH = 8, 1, 32) share one clock. A
// transaction-level model tracks, per instance, whether an operation is in
// flight, when its result becomes visible (WIDTH edges after acceptance) and
// the full-width sum it must carry. A compare process checks in_ready,
// out_valid and {out_cout,out_sum} against that model on every cycle.
// Directed tests on the 8-bit instance pin literal results and timing; the
// 1- and 32-bit instances get random operands with random output stalls.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst;
    logic [NI-1:0] in_valid;
    logic [NI-1:0] in_cin;
    logic [NI-1:0] out_ready;
    logic [31:0]   in_a [NI];
    logic [31:0]   in_b [NI];
    wire  [NI-1:0] in_ready;
    wire  [NI-1:0] out_valid;
    wire  [NI-1:0] out_cout;
    wire  [7:0]    sum8;
    wire  [0:0]    sum1;
    wire  [31:0]   sum32;
    logic [31:0]   out_sum [NI];

    assign out_sum[0] = {24'b0, sum8};
    assign out_sum[1] = {31'b0, sum1};
    assign out_sum[2] = sum32;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0][7:0]), .in_b(in_b[0][7:0]), .in_cin(in_cin[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum8), .out_cout(out_cout[0])
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1][0:0]), .in_b(in_b[1][0:0]), .in_cin(in_cin[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_cout(out_cout[1])
    );

    serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .in_cin(in_cin[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum32), .out_cout(out_cout[2])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wid(input int k);
        case (k)
            0:       return 8;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] wmask(input int k);
        logic [63:0] m;
        m = (64'd1 << wid(k)) - 64'd1;
        return m[31:0];
    endfunction

    // {out_cout, out_sum} of instance k as one number.
    function automatic logic [63:0] dut_result(input int k);
        return (64'(out_cout[k]) << wid(k)) | 64'(out_sum[k]);
    endfunction

    // ---------------- transaction-level model ----------------
    int          cyc = 0;
    bit          m_busy [NI];
    bit          m_have [NI];
    logic [63:0] m_exp  [NI];
    logic [63:0] m_last [NI];
    int          m_acc  [NI];
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NI; k++) begin
            if (rst[k]) begin
                m_busy[k] <= 1'b0;
                m_have[k] <= 1'b0;
                m_last[k] <= '0;
            end else if (!m_busy[k]) begin
                if (in_valid[k]) begin
                    m_busy[k] <= 1'b1;
                    m_exp[k]  <= 64'(in_a[k] & wmask(k)) + 64'(in_b[k] & wmask(k)) + 64'(in_cin[k]);
                    m_acc[k]  <= cyc;
                end
            end else if (!m_have[k]) begin
                if (cyc - m_acc[k] == wid(k)) begin
                    m_have[k] <= 1'b1;
                    m_last[k] <= m_exp[k];
                end
            end else if (out_ready[k]) begin
                m_busy[k] <= 1'b0;
                m_have[k] <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("in_ready[w%0d]", wid(k)), 64'(in_ready[k]), 64'(!m_busy[k]));
                check($sformatf("out_valid[w%0d]", wid(k)), 64'(out_valid[k]), 64'(m_have[k]));
                check($sformatf("result[w%0d]", wid(k)), dut_result(k), m_last[k]);
            end
        end
    end

    // One complete operation on instance k. lat counts edges from the
    // accepting edge to the edge after which out_valid is first seen.
    // rdy_after is in_ready sampled in the cycle after the output handshake.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input int stall, input bit wiggle, input bit pulse,
                          output logic [63:0] res, output int lat, output logic rdy_after);
        int n;
        n = 0;
        while (!in_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n >= 200), 64'd0);
        out_ready[k] = (stall == 0);
        in_valid[k]  = 1'b1;
        in_a[k]      = a & wmask(k);
        in_b[k]      = b & wmask(k);
        in_cin[k]    = cin;
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 100) begin
            if (wiggle) begin
                in_a[k]   = $urandom & wmask(k);
                in_b[k]   = $urandom & wmask(k);
                in_cin[k] = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        check("result_timeout", 64'(lat >= 100), 64'd0);
        res = dut_result(k);
        for (int i = 0; i < stall; i++) begin
            in_valid[k] = pulse && (i == 2);
            in_a[k]     = 32'h0000_0077 & wmask(k);
            in_b[k]     = 32'h0000_0011 & wmask(k);
            @(negedge clk);
            if (pulse) begin
                check("stall_valid", 64'(out_valid[k]), 64'd1);
                check("stall_ready", 64'(in_ready[k]), 64'd0);
                check("stall_result", dut_result(k), res);
            end
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(negedge clk);
        rdy_after = in_ready[k];
    endtask

    task automatic random_ops(input int k);
        logic [31:0] a, b;
        logic        cin;
        logic [63:0] res;
        int          lat;
        logic        rdy;
        for (int i = 0; i < 1000; i++) begin
            a   = $urandom & wmask(k);
            b   = $urandom & wmask(k);
            cin = 1'($urandom);
            run_op(k, a, b, cin, $urandom_range(0, 3), 1'b0, 1'b0, res, lat, rdy);
            check($sformatf("rand_sum[w%0d]", wid(k)), res, 64'(a) + 64'(b) + 64'(cin));
            check($sformatf("rand_lat[w%0d]", wid(k)), 64'(lat), 64'(wid(k)));
        end
    endtask

    initial begin
        #(100_000 * 10);
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] res;
        int          lat;
        logic        rdy;

        rst       = '1;
        in_valid  = '0;
        in_cin    = '0;
        out_ready = '1;
        for (int k = 0; k < NI; k++) begin
            in_a[k] = '0;
            in_b[k] = '0;
        end
        repeat (2) @(negedge clk);
        rst = '0;
        for (int k = 0; k < NI; k++) begin
            check("reset_in_ready", 64'(in_ready[k]), 64'd1);
            check("reset_out_valid", 64'(out_valid[k]), 64'd0);
            check("reset_result", dut_result(k), 64'd0);
        end
        chk_en = 1'b1;

        // FF + 01: wraps completely into the carry.
        run_op(0, 32'hFF, 32'h01, 1'b0, 0, 1'b0, 1'b0, res, lat, rdy);
        check("ff_01_sum", res, 64'h100);
        check("ff_01_lat", 64'(lat), 64'd8);
        check("ff_01_ready_again", 64'(rdy), 64'd1);

        run_op(0, 32'hA5, 32'h5A, 1'b1, 0, 1'b0, 1'b0, res, lat, rdy);
        check("a5_5a_1_sum", res, 64'h100);
        run_op(0, 32'h12, 32'h34, 1'b0, 0, 1'b0, 1'b0, res, lat, rdy);
        check("12_34_sum", res, 64'h046);

        // Backpressure with an ignored in_valid pulse while DONE is held.
        run_op(0, 32'h0F, 32'h01, 1'b0, 5, 1'b0, 1'b1, res, lat, rdy);
        check("bp_sum", res, 64'h010);
        repeat (3) @(negedge clk);
        check("bp_no_extra_op", 64'(in_ready[0]), 64'd1);

        // Operands changing every RUN cycle must not disturb the sum.
        run_op(0, 32'h3C, 32'h0F, 1'b1, 0, 1'b1, 1'b0, res, lat, rdy);
        check("wiggle_sum", res, 64'h04C);

        // Reset on the 4th RUN cycle discards the operation.
        in_valid[0] = 1'b1;
        in_a[0]     = 32'hC3;
        in_b[0]     = 32'h3C;
        in_cin[0]   = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
        check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
        check("midrst_result", dut_result(0), 64'd0);
        repeat (12) @(negedge clk);
        check("midrst_no_stale", 64'(out_valid[0]), 64'd0);
        run_op(0, 32'h03, 32'h04, 1'b0, 0, 1'b0, 1'b0, res, lat, rdy);
        check("after_rst_sum", res, 64'h007);

        // Random traffic on the extreme widths, run side by side.
        fork
            random_ops(1);
            random_ops(2);
        join

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
